ddr_cmd_arbiter: RTL and testbench

DDR_CMD_ARBITER -- requirements
Module: ddr_cmd_arbiter

---
 rtl/ddr_arb_pkg.sv | 17 +
 rtl/ddr_cmd_arbiter_if.sv | 44 ++++
 rtl/ddr_arb_order_fifo.sv | 51 +++++
 rtl/ddr_cmd_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ddr_cmd_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared FSM encoding and requester indices for the DDR command arbiter
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    function automatic arb_state_e grant_state(input logic idx);
        return (idx == REQ_M1) ? ST_GRANT1 : ST_GRANT0;
    endfunction

endpackage

// File: rtl/ddr_cmd_arbiter_if.sv
// rtl/ddr_cmd_arbiter_if.sv - command beat channel plus read response channel of one port
interface ddr_cmd_arbiter_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   cmd_id;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_lock;
    logic [3:0]            cmd_cache;
    logic [2:0]            cmd_prot;
    logic [DATA_WIDTH-1:0] cmd_wr_data;
    logic [STRB_WIDTH-1:0] cmd_wr_strb;
    logic                  cmd_wr_en;
    logic                  cmd_rd_en;
    logic                  cmd_last;
    logic                  cmd_ready;

    logic [ID_WIDTH-1:0]   rd_resp_id;
    logic [DATA_WIDTH-1:0] rd_resp_data;
    logic                  rd_resp_last;
    logic                  rd_resp_valid;
    logic                  rd_resp_ready;

    // Issues commands and consumes read responses.
    modport master (
        output cmd_id, cmd_addr, cmd_lock, cmd_cache, cmd_prot,
        output cmd_wr_data, cmd_wr_strb, cmd_wr_en, cmd_rd_en, cmd_last,
        input  cmd_ready,
        input  rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid,
        output rd_resp_ready
    );

    // Accepts commands and produces read responses.
    modport slave (
        input  cmd_id, cmd_addr, cmd_lock, cmd_cache, cmd_prot,
        input  cmd_wr_data, cmd_wr_strb, cmd_wr_en, cmd_rd_en, cmd_last,
        output cmd_ready,
        output rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid,
        input  rd_resp_ready
    );

endinterface

// File: rtl/ddr_arb_order_fifo.sv
// rtl/ddr_arb_order_fifo.sv - 1-bit FIFO recording which requester owns each outstanding read burst
module ddr_arb_order_fifo
    import ddr_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic push_i,
    input  logic push_data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DEPTH-1:0] mem_q;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage and pointer update; push and pop in one cycle both take effect.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// rtl/ddr_cmd_arbiter.sv - two-requester burst arbiter in front of a DDR controller with in-order response routing
module ddr_cmd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int ORDER_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    ddr_cmd_arbiter_if.slave       m0,
    ddr_cmd_arbiter_if.slave       m1,
    ddr_cmd_arbiter_if.master      ram,
    output logic                   order_err
);
    arb_state_e state_q;
    logic       rr_last_q;
    logic       order_err_q;

    logic       gnt0;
    logic       gnt1;
    logic       pend0;
    logic       pend1;
    logic       elig0;
    logic       elig1;
    logic       pick_valid;
    logic       pick_idx;
    logic       pick_rd;
    logic       last_acc;

    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       resp_route;
    logic       resp_ready;

    logic [ID_WIDTH-1:0]   sel_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_lock;
    logic [3:0]            sel_cache;
    logic [2:0]            sel_prot;
    logic [DATA_WIDTH-1:0] sel_wr_data;
    logic [STRB_WIDTH-1:0] sel_wr_strb;
    logic                  sel_wr_en;
    logic                  sel_rd_en;
    logic                  sel_last;

    assign gnt0 = (state_q == ST_GRANT0);
    assign gnt1 = (state_q == ST_GRANT1);

    // A read cannot start while every order slot is taken; a write always can.
    assign pend0 = m0.cmd_wr_en | m0.cmd_rd_en;
    assign pend1 = m1.cmd_wr_en | m1.cmd_rd_en;
    assign elig0 = pend0 & ~(m0.cmd_rd_en & fifo_full);
    assign elig1 = pend1 & ~(m1.cmd_rd_en & fifo_full);

    // Round-robin pick among eligible requesters, favouring the one not granted last.
    always_comb begin
        pick_valid = elig0 | elig1;
        pick_idx   = REQ_M0;
        if (elig0 && elig1) begin
            pick_idx = (rr_last_q == REQ_M0) ? REQ_M1 : REQ_M0;
        end else if (elig1) begin
            pick_idx = REQ_M1;
        end
    end

    assign pick_rd   = (pick_idx == REQ_M1) ? m1.cmd_rd_en : m0.cmd_rd_en;
    assign fifo_push = (state_q == ST_IDLE) & pick_valid & pick_rd;

    // Zero-latency command path: the granted requester drives the controller directly.
    always_comb begin
        sel_id      = '0;
        sel_addr    = '0;
        sel_lock    = 1'b0;
        sel_cache   = '0;
        sel_prot    = '0;
        sel_wr_data = '0;
        sel_wr_strb = '0;
        sel_wr_en   = 1'b0;
        sel_rd_en   = 1'b0;
        sel_last    = 1'b0;
        if (gnt0) begin
            sel_id      = m0.cmd_id;
            sel_addr    = m0.cmd_addr;
            sel_lock    = m0.cmd_lock;
            sel_cache   = m0.cmd_cache;
            sel_prot    = m0.cmd_prot;
            sel_wr_data = m0.cmd_wr_data;
            sel_wr_strb = m0.cmd_wr_strb;
            sel_wr_en   = m0.cmd_wr_en;
            sel_rd_en   = m0.cmd_rd_en;
            sel_last    = m0.cmd_last;
        end else if (gnt1) begin
            sel_id      = m1.cmd_id;
            sel_addr    = m1.cmd_addr;
            sel_lock    = m1.cmd_lock;
            sel_cache   = m1.cmd_cache;
            sel_prot    = m1.cmd_prot;
            sel_wr_data = m1.cmd_wr_data;
            sel_wr_strb = m1.cmd_wr_strb;
            sel_wr_en   = m1.cmd_wr_en;
            sel_rd_en   = m1.cmd_rd_en;
            sel_last    = m1.cmd_last;
        end
    end

    assign ram.cmd_id      = sel_id;
    assign ram.cmd_addr    = sel_addr;
    assign ram.cmd_lock    = sel_lock;
    assign ram.cmd_cache   = sel_cache;
    assign ram.cmd_prot    = sel_prot;
    assign ram.cmd_wr_data = sel_wr_data;
    assign ram.cmd_wr_strb = sel_wr_strb;
    assign ram.cmd_wr_en   = sel_wr_en;
    assign ram.cmd_rd_en   = sel_rd_en;
    assign ram.cmd_last    = sel_last;

    assign m0.cmd_ready = gnt0 & ram.cmd_ready;
    assign m1.cmd_ready = gnt1 & ram.cmd_ready;

    // The burst ends when its last beat is taken by the controller.
    assign last_acc = (sel_wr_en | sel_rd_en) & ram.cmd_ready & sel_last;

    // Grant FSM: IDLE picks a requester, GRANTn holds until that burst's last beat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            rr_last_q <= REQ_M1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q   <= grant_state(pick_idx);
                        rr_last_q <= pick_idx;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (last_acc) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ddr_arb_order_fifo #(
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (fifo_push),
        .push_data_i (pick_idx),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    // Responses follow issue order; with nothing outstanding they are refused.
    assign resp_route = ~fifo_empty;
    assign resp_ready = resp_route &
                        ((fifo_head == REQ_M1) ? m1.rd_resp_ready : m0.rd_resp_ready);
    assign fifo_pop   = ram.rd_resp_valid & resp_ready & ram.rd_resp_last;

    assign ram.rd_resp_ready = resp_ready;

    assign m0.rd_resp_id    = ram.rd_resp_id;
    assign m0.rd_resp_data  = ram.rd_resp_data;
    assign m0.rd_resp_last  = ram.rd_resp_last;
    assign m0.rd_resp_valid = ram.rd_resp_valid & resp_route & (fifo_head == REQ_M0);

    assign m1.rd_resp_id    = ram.rd_resp_id;
    assign m1.rd_resp_data  = ram.rd_resp_data;
    assign m1.rd_resp_last  = ram.rd_resp_last;
    assign m1.rd_resp_valid = ram.rd_resp_valid & resp_route & (fifo_head == REQ_M1);

    // Sticky flag for a response that no outstanding read can own.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            order_err_q <= 1'b0;
        end else if (ram.rd_resp_valid && fifo_empty) begin
            order_err_q <= 1'b1;
        end
    end

    assign order_err = order_err_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// tb/tb_ddr_cmd_arbiter.sv - directed self-checking bench for ddr_cmd_arbiter
module tb_ddr_cmd_arbiter;

    logic clk;
    logic resetn;
    logic order_err;

    int total = 0;
    int bad   = 0;

    ddr_cmd_arbiter_if #(.DATA_WIDTH(256), .ADDR_WIDTH(32), .ID_WIDTH(8)) m0_if ();
    ddr_cmd_arbiter_if #(.DATA_WIDTH(256), .ADDR_WIDTH(32), .ID_WIDTH(8)) m1_if ();
    ddr_cmd_arbiter_if #(.DATA_WIDTH(256), .ADDR_WIDTH(32), .ID_WIDTH(8)) ram_if ();

    ddr_cmd_arbiter #(
        .DATA_WIDTH  (256),
        .ADDR_WIDTH  (32),
        .ID_WIDTH    (8),
        .ORDER_DEPTH (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m0        (m0_if),
        .m1        (m1_if),
        .ram       (ram_if),
        .order_err (order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_m(input int idx, input logic wr, input logic rd,
                         input logic [7:0] id, input logic [31:0] addr, input logic last);
        if (idx == 0) begin
            m0_if.cmd_wr_en   = wr;
            m0_if.cmd_rd_en   = rd;
            m0_if.cmd_id      = id;
            m0_if.cmd_addr    = addr;
            m0_if.cmd_last    = last;
            m0_if.cmd_wr_data = {8{addr}};
            m0_if.cmd_wr_strb = '1;
            m0_if.cmd_lock    = 1'b0;
            m0_if.cmd_cache   = 4'h3;
            m0_if.cmd_prot    = 3'h0;
        end else begin
            m1_if.cmd_wr_en   = wr;
            m1_if.cmd_rd_en   = rd;
            m1_if.cmd_id      = id;
            m1_if.cmd_addr    = addr;
            m1_if.cmd_last    = last;
            m1_if.cmd_wr_data = {8{addr}};
            m1_if.cmd_wr_strb = '1;
            m1_if.cmd_lock    = 1'b1;
            m1_if.cmd_cache   = 4'h5;
            m1_if.cmd_prot    = 3'h2;
        end
    endtask

    task automatic set_resp(input logic valid, input logic [7:0] id,
                            input logic [63:0] data, input logic last);
        ram_if.rd_resp_valid = valid;
        ram_if.rd_resp_id    = id;
        ram_if.rd_resp_data  = {4{data}};
        ram_if.rd_resp_last  = last;
    endtask

    int g_exp [12] = '{-1, 1, 1, -1, 0, 0, -1, 1, 1, -1, 0, 0};
    int c0;
    int c1;
    int n;

    initial begin
        resetn = 1'b0;
        set_m(0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0);
        set_m(1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        set_resp(1'b0, 8'h00, 64'h0, 1'b0);
        ram_if.cmd_ready     = 1'b1;
        m0_if.rd_resp_ready  = 1'b1;
        m1_if.rd_resp_ready  = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_m0_rdy", m0_if.cmd_ready, 1'b0);
        chk("rst_m1_rdy", m1_if.cmd_ready, 1'b0);
        chk("rst_ram_wr", ram_if.cmd_wr_en, 1'b0);
        chk("rst_ram_rd", ram_if.cmd_rd_en, 1'b0);
        chk("rst_m0_rv", m0_if.rd_resp_valid, 1'b0);
        chk("rst_ram_rr", ram_if.rd_resp_ready, 1'b0);
        chk("rst_oerr", order_err, 1'b0);
        set_m(0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        resetn = 1'b1;

        // m0 write burst of 4 beats
        @(negedge clk);
        set_m(0, 1'b1, 1'b0, 8'h0a, 32'h100, 1'b0);
        #1;
        chk("w4_idle_rdy", m0_if.cmd_ready, 1'b0);
        chk("w4_idle_en", ram_if.cmd_wr_en, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_m(0, 1'b1, 1'b0, 8'h0a, 32'h100 + i, i == 3);
            #1;
            chk("w4_rdy", m0_if.cmd_ready, 1'b1);
            chk("w4_en", ram_if.cmd_wr_en, 1'b1);
            chk("w4_addr", ram_if.cmd_addr, 32'h100 + i);
            chk("w4_data", ram_if.cmd_wr_data[63:0], {2{32'h100 + i}});
            chk("w4_last", ram_if.cmd_last, i == 3);
        end
        @(negedge clk);
        set_m(0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        #1;
        chk("w4_back_idle", m0_if.cmd_ready, 1'b0);

        // both requesters issue 2-beat writes back to back
        c0 = 0;
        c1 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            set_m(0, 1'b1, 1'b0, 8'h01, 32'h1000 + c0, c0[0]);
            set_m(1, 1'b1, 1'b0, 8'h02, 32'h2000 + c1, c1[0]);
            #1;
            chk("alt_rdy0", m0_if.cmd_ready, g_exp[c] == 0);
            chk("alt_rdy1", m1_if.cmd_ready, g_exp[c] == 1);
            if (g_exp[c] == 0) begin
                chk("alt_addr0", ram_if.cmd_addr, 32'h1000 + c0);
                chk("alt_id0", ram_if.cmd_id, 8'h01);
                c0++;
            end else if (g_exp[c] == 1) begin
                chk("alt_addr1", ram_if.cmd_addr, 32'h2000 + c1);
                chk("alt_id1", ram_if.cmd_id, 8'h02);
                chk("alt_cache1", ram_if.cmd_cache, 4'h5);
                c1++;
            end
        end
        @(negedge clk);
        set_m(0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        set_m(1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);

        // controller back-pressure mid-burst
        @(negedge clk);
        set_m(1, 1'b1, 1'b0, 8'h05, 32'h500, 1'b0);
        #1;
        chk("bp_idle", m1_if.cmd_ready, 1'b0);
        @(negedge clk); #1;
        chk("bp_b0_rdy", m1_if.cmd_ready, 1'b1);
        chk("bp_b0_addr", ram_if.cmd_addr, 32'h500);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                set_m(1, 1'b1, 1'b0, 8'h05, 32'h501, 1'b0);
                ram_if.cmd_ready = 1'b0;
            end
            #1;
            chk("bp_stall_rdy", m1_if.cmd_ready, 1'b0);
            chk("bp_stall_addr", ram_if.cmd_addr, 32'h501);
            chk("bp_stall_en", ram_if.cmd_wr_en, 1'b1);
        end
        @(negedge clk);
        ram_if.cmd_ready = 1'b1;
        #1;
        chk("bp_b1_rdy", m1_if.cmd_ready, 1'b1);
        chk("bp_b1_addr", ram_if.cmd_addr, 32'h501);
        @(negedge clk);
        set_m(1, 1'b1, 1'b0, 8'h05, 32'h502, 1'b1);
        #1;
        chk("bp_b2_rdy", m1_if.cmd_ready, 1'b1);
        chk("bp_b2_last", ram_if.cmd_last, 1'b1);
        @(negedge clk);
        set_m(1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        #1;
        chk("bp_done", m1_if.cmd_ready, 1'b0);

        // m0 read 0x11 then m1 read 0x22, responses in order
        @(negedge clk);
        set_m(0, 1'b0, 1'b1, 8'h11, 32'h700, 1'b1);
        #1;
        chk("rd0_idle", m0_if.cmd_ready, 1'b0);
        @(negedge clk); #1;
        chk("rd0_rdy", m0_if.cmd_ready, 1'b1);
        chk("rd0_en", ram_if.cmd_rd_en, 1'b1);
        chk("rd0_id", ram_if.cmd_id, 8'h11);
        @(negedge clk);
        set_m(0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        set_m(1, 1'b0, 1'b1, 8'h22, 32'h800, 1'b1);
        #1;
        chk("rd1_idle", m1_if.cmd_ready, 1'b0);
        @(negedge clk); #1;
        chk("rd1_rdy", m1_if.cmd_ready, 1'b1);
        chk("rd1_id", ram_if.cmd_id, 8'h22);
        @(negedge clk);
        set_m(1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        set_resp(1'b1, 8'h11, 64'haaaa, 1'b0);
        #1;
        chk("rsp11_v0", m0_if.rd_resp_valid, 1'b1);
        chk("rsp11_v1", m1_if.rd_resp_valid, 1'b0);
        chk("rsp11_id", m0_if.rd_resp_id, 8'h11);
        chk("rsp11_data", m0_if.rd_resp_data[63:0], 64'haaaa);
        chk("rsp11_rr", ram_if.rd_resp_ready, 1'b1);
        @(negedge clk);
        set_resp(1'b1, 8'h11, 64'hbbbb, 1'b1);
        m0_if.rd_resp_ready = 1'b0;
        #1;
        chk("rsp11_bp", ram_if.rd_resp_ready, 1'b0);
        @(negedge clk);
        m0_if.rd_resp_ready = 1'b1;
        #1;
        chk("rsp11_last_v0", m0_if.rd_resp_valid, 1'b1);
        chk("rsp11_last_rr", ram_if.rd_resp_ready, 1'b1);
        @(negedge clk);
        set_resp(1'b1, 8'h22, 64'hcccc, 1'b0);
        #1;
        chk("rsp22_v1", m1_if.rd_resp_valid, 1'b1);
        chk("rsp22_v0", m0_if.rd_resp_valid, 1'b0);
        chk("rsp22_id", m1_if.rd_resp_id, 8'h22);
        @(negedge clk);
        set_resp(1'b1, 8'h22, 64'hdddd, 1'b1);
        #1;
        chk("rsp22_data", m1_if.rd_resp_data[63:0], 64'hdddd);
        chk("rsp22_v0b", m0_if.rd_resp_valid, 1'b0);
        @(negedge clk);
        set_resp(1'b0, 8'h00, 64'h0, 1'b0);

        // fill all eight order slots, then a write must overtake the held read
        @(negedge clk);
        set_m(0, 1'b0, 1'b1, 8'h30, 32'h900, 1'b1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (m0_if.cmd_ready) n++;
            if (n == 8) break;
            @(negedge clk);
        end
        chk("fill_cnt", n, 8);
        @(negedge clk);
        set_m(1, 1'b1, 1'b0, 8'h31, 32'h3000, 1'b1);
        #1;
        chk("full_idle0", m0_if.cmd_ready, 1'b0);
        chk("full_idle1", m1_if.cmd_ready, 1'b0);
        @(negedge clk); #1;
        chk("full_wr_rdy1", m1_if.cmd_ready, 1'b1);
        chk("full_wr_rdy0", m0_if.cmd_ready, 1'b0);
        chk("full_wr_addr", ram_if.cmd_addr, 32'h3000);
        @(negedge clk);
        set_m(1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        #1;
        chk("full_hold_a", m0_if.cmd_ready, 1'b0);
        @(negedge clk); #1;
        chk("full_hold_b", m0_if.cmd_ready, 1'b0);
        @(negedge clk);
        set_resp(1'b1, 8'h30, 64'h1, 1'b1);
        #1;
        chk("full_pop_v0", m0_if.rd_resp_valid, 1'b1);
        chk("full_hold_c", m0_if.cmd_ready, 1'b0);
        @(negedge clk);
        set_resp(1'b0, 8'h00, 64'h0, 1'b0);
        #1;
        chk("full_hold_d", m0_if.cmd_ready, 1'b0);
        @(negedge clk); #1;
        chk("full_rd_go", m0_if.cmd_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) set_m(0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
            set_resp(1'b1, 8'h30, 64'h10 + k, 1'b1);
            #1;
            chk("drain_v0", m0_if.rd_resp_valid, 1'b1);
            chk("drain_rr", ram_if.rd_resp_ready, 1'b1);
        end
        @(negedge clk);
        set_resp(1'b0, 8'h00, 64'h0, 1'b0);
        #1;
        chk("drain_oerr", order_err, 1'b0);

        // reset mid-burst discards the outstanding read
        @(negedge clk);
        set_m(0, 1'b0, 1'b1, 8'h40, 32'ha00, 1'b1);
        #1;
        chk("mrst_idle", m0_if.cmd_ready, 1'b0);
        @(negedge clk); #1;
        chk("mrst_gnt", m0_if.cmd_ready, 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        set_m(0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
        #1;
        chk("mrst_rdy", m0_if.cmd_ready, 1'b0);
        chk("mrst_rd_en", ram_if.cmd_rd_en, 1'b0);
        resetn = 1'b1;

        // response with nothing outstanding
        @(negedge clk);
        set_resp(1'b1, 8'h40, 64'h5, 1'b1);
        #1;
        chk("oe_rr", ram_if.rd_resp_ready, 1'b0);
        chk("oe_v0", m0_if.rd_resp_valid, 1'b0);
        chk("oe_v1", m1_if.rd_resp_valid, 1'b0);
        chk("oe_pre", order_err, 1'b0);
        @(negedge clk);
        set_resp(1'b0, 8'h00, 64'h0, 1'b0);
        #1;
        chk("oe_set", order_err, 1'b1);
        @(negedge clk); #1;
        chk("oe_hold", order_err, 1'b1);
        resetn = 1'b0;
        @(negedge clk); #1;
        chk("oe_clr", order_err, 1'b0);
        resetn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
